// File: rtl/dft_pkg.sv
// Shared constants and FSM encoding for the single-bin Goertzel DFT engine.
package dft_pkg;
  localparam int DATA_W   = 12;
  localparam int CNT_W    = 9;
  localparam int COEF_W   = 18;
  localparam int FRAC_W   = 16;
  localparam int ACC_W    = 32;
  localparam int RD_LAT   = 1;
  localparam int COEF_ONE = 1 << FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ITER,
    S_PWR0,
    S_PWR1,
    S_OUT
  } state_e;
endpackage

// File: rtl/dft_goertzel_if.sv
// FIFO read port plus valid/ready result port of the Goertzel engine.
interface dft_goertzel_if #(
  parameter int DATA_W = dft_pkg::DATA_W,
  parameter int ACC_W  = dft_pkg::ACC_W
) ();
  logic [DATA_W-1:0]  fifo_rdata;
  logic               fifo_rd;
  logic               fifo_empty;
  logic [ACC_W-1:0]   res_q1;
  logic [ACC_W-1:0]   res_q2;
  logic [2*ACC_W-1:0] res_power;
  logic               res_valid;
  logic               res_ready;

  modport master (
    input  fifo_rdata, fifo_empty, res_ready,
    output fifo_rd, res_q1, res_q2,
    output res_power, res_valid
  );

  modport slave (
    output fifo_rdata, fifo_empty, res_ready,
    input  fifo_rd, res_q1, res_q2,
    input  res_power, res_valid
  );
endinterface

// File: rtl/dft_goertzel_mac.sv
// Signed multiply, arithmetic shift (floor) and wrapping add.
module dft_goertzel_mac #(
  parameter int A_W = dft_pkg::COEF_W,
  parameter int B_W = dft_pkg::ACC_W,
  parameter int O_W = dft_pkg::ACC_W,
  parameter int SH  = dft_pkg::FRAC_W
) (
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  input  logic signed [O_W-1:0]     c_i,
  output logic signed [A_W+B_W-1:0] prod_o,
  output logic signed [O_W-1:0]     sum_o
);
  assign prod_o = a_i * b_i;
  assign sum_o  = c_i + O_W'(prod_o >>> SH);
endmodule

// File: rtl/dft_goertzel.sv
// Goertzel single-bin DFT: drains N samples from a FIFO, returns q1, q2, power.
module dft_goertzel #(
  parameter int DATA_W = dft_pkg::DATA_W,
  parameter int CNT_W  = dft_pkg::CNT_W,
  parameter int COEF_W = dft_pkg::COEF_W,
  parameter int FRAC_W = dft_pkg::FRAC_W,
  parameter int ACC_W  = dft_pkg::ACC_W,
  parameter int RD_LAT = dft_pkg::RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         n_samples,
  input  logic signed [COEF_W-1:0] coeff,
  output logic                     busy,
  dft_goertzel_if.master           bus
);
  import dft_pkg::*;

  localparam int P_W = 2 * ACC_W;
  localparam int M_W = COEF_W + ACC_W;
  localparam int B_W = M_W + ACC_W;
  localparam int L_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e state_q, state_d;

  logic [CNT_W-1:0]         n_q, cnt_q;
  logic [L_W-1:0]           lat_q;
  logic signed [COEF_W-1:0] coef_q;
  logic signed [ACC_W-1:0]  q1_q, q2_q;
  logic signed [ACC_W-1:0]  x_d, c_d, qn_d;
  logic signed [M_W-1:0]    prod_d, prod_q;
  logic signed [P_W-1:0]    sq_d, sq_q, pw_d;
  logic signed [B_W-1:0]    big_d;
  logic [ACC_W-1:0]         rq1_q, rq2_q;
  logic [P_W-1:0]           rpw_q;
  logic                     rv_q;
  logic                     rd, done;

  assign done = (cnt_q == n_q);
  assign x_d  = ACC_W'($signed(bus.fifo_rdata));
  assign c_d  = x_d - q2_q;

  // ITER takes the sum, PWR0 registers the full coeff*q1 product
  dft_goertzel_mac #(
    .A_W(COEF_W),
    .B_W(ACC_W),
    .O_W(ACC_W),
    .SH (FRAC_W)
  ) u_mac (
    .a_i   (coef_q),
    .b_i   (q1_q),
    .c_i   (c_d),
    .prod_o(prod_d),
    .sum_o (qn_d)
  );

  assign sq_d  = P_W'(q1_q) * P_W'(q1_q)
               + P_W'(q2_q) * P_W'(q2_q);
  assign big_d = B_W'(prod_q) * B_W'(q2_q);
  assign pw_d  = sq_q - P_W'(big_d >>> FRAC_W);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (done)                 state_d = S_PWR0;
        else if (!bus.fifo_empty) state_d = S_WAIT;
      end
      S_WAIT: if (lat_q == '0) state_d = S_ITER;
      S_ITER: state_d = S_REQ;
      S_PWR0: state_d = S_PWR1;
      S_PWR1: state_d = S_OUT;
      S_OUT:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    rd   = (state_q == S_REQ) && !done
        && !bus.fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q    <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
      coef_q <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
      prod_q <= '0;
      sq_q   <= '0;
      rq1_q  <= '0;
      rq2_q  <= '0;
      rpw_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        n_q    <= n_samples;
        coef_q <= coeff;
        cnt_q  <= '0;
        q1_q   <= '0;
        q2_q   <= '0;
      end
      if (rd) begin
        lat_q <= L_W'(RD_LAT - 1);
      end else if (state_q == S_WAIT && lat_q != '0) begin
        lat_q <= lat_q - 1'b1;
      end
      if (state_q == S_ITER) begin
        q1_q  <= qn_d;
        q2_q  <= q1_q;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_PWR0) begin
        prod_q <= prod_d;
        sq_q   <= sq_d;
      end
      if (state_q == S_PWR1) begin
        rq1_q <= q1_q;
        rq2_q <= q2_q;
        rpw_q <= pw_d;
        rv_q  <= 1'b1;
      end
      if (state_q == S_OUT && bus.res_ready) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign bus.fifo_rd   = rd;
  assign bus.res_q1    = rq1_q;
  assign bus.res_q2    = rq2_q;
  assign bus.res_power = rpw_q;
  assign bus.res_valid = rv_q;
endmodule
